// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and load/store requests onto a single byte-serial memory controller.
// LS has priority; a starvation counter forces an IF grant after STARVE_LIMIT LS wins.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  output logic        if_is_c,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_type,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mc_if_enable,
  output logic [31:0] mc_inst_addr,
  output logic        mc_ls_enable,
  output logic [31:0] mc_ls_addr,
  output logic [31:0] mc_store_val,
  output logic [3:0]  mc_lsb_type,
  input  logic        mc_if_ready,
  input  logic [31:0] mc_inst,
  input  logic        mc_is_c,
  input  logic        mc_ls_finished,
  input  logic [31:0] mc_load_val,
  output logic        mc_clear,
  output logic [2:0]  state_dbg
);

  // Handshake: a requester raises *_req with stable fields and holds them until it
  // samples *_done high on a rising edge; *_done is a one-cycle pulse and the
  // requester drops *_req on that same edge. Only one transaction is ever in flight.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_IF = 3'd1,
    ISSUE_LS = 3'd2,
    BUSY_IF  = 3'd3,
    BUSY_LS  = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lat_if, lat_ls;
  logic             flush;
  logic             is_store;

  assign flush     = rdy_in & clear;
  assign is_store  = mc_lsb_type[3];
  assign state_dbg = state_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mc_inst_addr <= '0;
      mc_ls_addr   <= '0;
      mc_store_val <= '0;
      mc_lsb_type  <= 4'b0111;
    end else begin
      if (lat_if) mc_inst_addr <= if_addr;
      if (lat_ls) begin
        mc_ls_addr   <= ls_addr;
        mc_store_val <= ls_wdata;
        mc_lsb_type  <= ls_type;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_if       = 1'b0;
    lat_ls       = 1'b0;
    mc_if_enable = 1'b0;
    mc_ls_enable = 1'b0;
    mc_clear     = 1'b0;
    if_done      = 1'b0;
    ls_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          mc_clear = 1'b1;
          cnt_d    = '0;
        end else if (rdy_in && !io_buffer_full) begin
          if (ls_req && !(if_req && cnt_q == LIMIT)) begin
            lat_ls  = 1'b1;
            state_d = ISSUE_LS;
            if (if_req && cnt_q < LIMIT) cnt_d = cnt_q + 1'b1;
          end else if (if_req) begin
            lat_if  = 1'b1;
            state_d = ISSUE_IF;
            cnt_d   = '0;
          end
        end
      end
      ISSUE_IF: begin
        if (flush) begin
          mc_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (rdy_in) begin
          mc_if_enable = 1'b1;
          state_d      = BUSY_IF;
        end
      end
      ISSUE_LS: begin
        // A store already selected is always issued; a flush then waits for it in DRAIN.
        if (flush && !is_store) begin
          mc_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (rdy_in) begin
          mc_ls_enable = 1'b1;
          state_d      = flush ? DRAIN : BUSY_LS;
        end
      end
      BUSY_IF: begin
        if (flush) begin
          mc_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          if_done = mc_if_ready;
          if (rdy_in && mc_if_ready) state_d = IDLE;
        end
      end
      BUSY_LS: begin
        if (flush && !is_store) begin
          mc_clear = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          ls_done = mc_ls_finished;
          if (rdy_in && mc_ls_finished) state_d = IDLE;
          else if (flush)               state_d = DRAIN;
        end
      end
      DRAIN: begin
        ls_done = mc_ls_finished;
        if (rdy_in && mc_ls_finished) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_inst  = if_done ? mc_inst : '0;
  assign if_is_c  = if_done & mc_is_c;
  assign ls_rdata = ls_done ? mc_load_val : '0;

endmodule
